// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the rv32i core's two memory ports and a shared memory.
//   i*  : instruction port (read-only): iaddress, iread -> ireaddata, iwaitrequest
//   d*  : data port (read/write): daddress, dread, dwrite, dwritedata, dbyteenable
//         -> dreaddata, dwaitrequest
//   m*  : shared memory side: maddress, mread, mwrite, mwritedata, mbyteenable
//         <- mreaddata, mwaitrequest
// slave modport is the arbiter's view; master modport is the environment's
// view (requesters plus memory).
interface rv32_mem_arbiter_if;
  logic [31:0] iaddress;
  logic        iread;
  logic [31:0] ireaddata;
  logic        iwaitrequest;

  logic [31:0] daddress;
  logic        dwrite;
  logic [31:0] dwritedata;
  logic [3:0]  dbyteenable;
  logic        dread;
  logic [31:0] dreaddata;
  logic        dwaitrequest;

  logic [31:0] maddress;
  logic        mwrite;
  logic [31:0] mwritedata;
  logic [3:0]  mbyteenable;
  logic        mread;
  logic [31:0] mreaddata;
  logic        mwaitrequest;

  modport slave (
    input  iaddress, iread, daddress, dwrite, dwritedata, dbyteenable, dread,
           mreaddata, mwaitrequest,
    output ireaddata, iwaitrequest, dreaddata, dwaitrequest,
           maddress, mwrite, mwritedata, mbyteenable, mread
  );

  modport master (
    output iaddress, iread, daddress, dwrite, dwritedata, dbyteenable, dread,
           mreaddata, mwaitrequest,
    input  ireaddata, iwaitrequest, dreaddata, dwaitrequest,
           maddress, mwrite, mwritedata, mbyteenable, mread
  );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Two-requester arbiter sharing one waitrequest-style memory between the
// instruction port (read-only) and the data port (read/write).
// Data has priority; after STARVE_LIMIT consecutive completed data transfers
// with iread pending, instruction wins the next arbitration. A grant stalled
// by mwaitrequest is locked until the transfer completes or the owner drops
// its strobe. Grant muxing is combinational, so there is no added latency.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : rv32_mem_arbiter_if.slave (instruction, data and memory buses)
//   arb_owner : current owner, 0 = none, 1 = instr, 2 = data
module rv32_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // 1..15
) (
  input  logic                     clk,
  input  logic                     reset,
  rv32_mem_arbiter_if.slave        bus,
  output logic [1:0]               arb_owner
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StArb, StLockI, StLockD} state_e;

  state_e     state_q, state_d;
  logic [3:0] scnt_q, scnt_d;

  logic dreq;
  logic gnt_i, gnt_d;
  logic strobe, done;

  assign dreq = bus.dread | bus.dwrite;

  // Grant: locked side while locked, otherwise priority arbitration.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    unique case (state_q)
      StLockI: gnt_i = 1'b1;
      StLockD: gnt_d = 1'b1;
      default: begin
        gnt_d = dreq & ~(bus.iread & (scnt_q == Limit));
        gnt_i = ~gnt_d & bus.iread;
      end
    endcase
  end

  // Owner's strobe and whether its transfer completes this cycle.
  assign strobe = (gnt_i & bus.iread) | (gnt_d & dreq);
  assign done   = strobe & ~bus.mwaitrequest;

  // Memory-side mux and requester stalls.
  always_comb begin
    bus.maddress     = bus.daddress;
    bus.mwritedata   = bus.dwritedata;
    bus.mbyteenable  = bus.dbyteenable;
    bus.mread        = 1'b0;
    bus.mwrite       = 1'b0;
    bus.iwaitrequest = 1'b1;
    bus.dwaitrequest = 1'b1;
    arb_owner        = 2'd0;
    if (gnt_d) begin
      bus.mread        = bus.dread;
      bus.mwrite       = bus.dwrite;
      bus.dwaitrequest = bus.mwaitrequest;
      arb_owner        = 2'd2;
    end else if (gnt_i) begin
      bus.maddress     = bus.iaddress;
      bus.mbyteenable  = 4'hF;  // instruction fetch is always a full word
      bus.mread        = bus.iread;
      bus.iwaitrequest = bus.mwaitrequest;
      arb_owner        = 2'd1;
    end
  end

  assign bus.ireaddata = bus.mreaddata;
  assign bus.dreaddata = bus.mreaddata;

  // Next state: lock while a started transfer stalls; release on completion
  // or when the owner withdraws its strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb: begin
        if (strobe && bus.mwaitrequest) begin
          state_d = gnt_d ? StLockD : StLockI;
        end
      end
      StLockI, StLockD: begin
        if (!strobe || done) begin
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  // Starvation counter: counts completed data transfers while iread waits.
  always_comb begin
    scnt_d = scnt_q;
    if (!bus.iread) begin
      scnt_d = 4'd0;
    end else if (done && gnt_i) begin
      scnt_d = 4'd0;
    end else if (done && gnt_d && (scnt_q < Limit)) begin
      scnt_d = scnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StArb;
      scnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
module tb_rv32_mem_arbiter;

  localparam int Limit = 4;

  logic       clk;
  logic       reset;
  logic [1:0] arb_owner;

  rv32_mem_arbiter_if bus ();

  rv32_mem_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .arb_owner (arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: who may use the memory, tracked as "locked owner" and a count of
  // data wins since instruction was last served.
  int m_lock = 0;  // 0 none, 1 instr, 2 data
  int m_cnt  = 0;
  int n_lock = 0;
  int n_cnt  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lock <= 0;
      m_cnt  <= 0;
    end else begin
      m_lock <= n_lock;
      m_cnt  <= n_cnt;
    end
  end

  always @(negedge clk) begin
    int own;
    bit dreq, strobe, done;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    bit e_rd, e_wr, e_iw, e_dw;
    dreq = bus.dread || bus.dwrite;
    if (m_lock != 0) own = m_lock;
    else if (dreq && !(bus.iread && m_cnt == Limit)) own = 2;
    else if (bus.iread) own = 1;
    else own = 0;

    e_addr = (own == 1) ? bus.iaddress : bus.daddress;
    e_wd   = bus.dwritedata;
    e_be   = (own == 1) ? 4'hF : bus.dbyteenable;
    e_rd   = (own == 1) ? bus.iread : (own == 2) ? bus.dread : 1'b0;
    e_wr   = (own == 2) ? bus.dwrite : 1'b0;
    e_iw   = (own == 1) ? bus.mwaitrequest : 1'b1;
    e_dw   = (own == 2) ? bus.mwaitrequest : 1'b1;

    check("m.owner", {30'd0, arb_owner}, own);
    check("m.maddress", bus.maddress, e_addr);
    check("m.mwritedata", bus.mwritedata, e_wd);
    check("m.mbyteenable", {28'd0, bus.mbyteenable}, {28'd0, e_be});
    check("m.mread", {31'd0, bus.mread}, {31'd0, e_rd});
    check("m.mwrite", {31'd0, bus.mwrite}, {31'd0, e_wr});
    check("m.iwait", {31'd0, bus.iwaitrequest}, {31'd0, e_iw});
    check("m.dwait", {31'd0, bus.dwaitrequest}, {31'd0, e_dw});
    check("m.ireaddata", bus.ireaddata, bus.mreaddata);
    check("m.dreaddata", bus.dreaddata, bus.mreaddata);

    strobe = (own == 1) ? bus.iread : (own == 2) ? dreq : 1'b0;
    done   = strobe && !bus.mwaitrequest;
    n_lock = (strobe && bus.mwaitrequest) ? own : 0;
    if (!bus.iread) n_cnt = 0;
    else if (done && own == 1) n_cnt = 0;
    else if (done && own == 2) n_cnt = (m_cnt < Limit) ? m_cnt + 1 : Limit;
    else n_cnt = m_cnt;
  end

  task automatic idle();
    bus.iaddress     = 32'h0;
    bus.iread        = 1'b0;
    bus.daddress     = 32'h0;
    bus.dwrite       = 1'b0;
    bus.dwritedata   = 32'h0;
    bus.dbyteenable  = 4'h0;
    bus.dread        = 1'b0;
    bus.mreaddata    = 32'h0;
    bus.mwaitrequest = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[6];
    int exp_starve[6];
    int exp_drop[4];
    exp_starve = '{2, 2, 2, 2, 1, 2};
    exp_drop   = '{2, 2, 2, 1};

    reset = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset.mread", {31'd0, bus.mread}, 32'd0);
    check("reset.mwrite", {31'd0, bus.mwrite}, 32'd0);
    check("reset.iwait", {31'd0, bus.iwaitrequest}, 32'd1);
    check("reset.dwait", {31'd0, bus.dwaitrequest}, 32'd1);
    check("reset.owner", {30'd0, arb_owner}, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Instruction-only, zero-wait memory
    for (int k = 0; k < 3; k++) begin
      bus.iread     = 1'b1;
      bus.iaddress  = 32'(4 * k);
      bus.mreaddata = 32'h1000_0000 + 32'(k);
      @(negedge clk);
      check("ionly.maddress", bus.maddress, 32'(4 * k));
      check("ionly.iwait", {31'd0, bus.iwaitrequest}, 32'd0);
      check("ionly.ireaddata", bus.ireaddata, 32'h1000_0000 + 32'(k));
      next_cycle();
    end
    idle();
    next_cycle();

    // Simultaneous instruction read and data write
    bus.iread       = 1'b1;
    bus.iaddress    = 32'h40;
    bus.dwrite      = 1'b1;
    bus.daddress    = 32'h100;
    bus.dwritedata  = 32'hDEAD_BEEF;
    bus.dbyteenable = 4'hF;
    @(negedge clk);
    check("simul.owner", {30'd0, arb_owner}, 32'd2);
    check("simul.mwrite", {31'd0, bus.mwrite}, 32'd1);
    check("simul.maddress", bus.maddress, 32'h100);
    check("simul.mwritedata", bus.mwritedata, 32'hDEAD_BEEF);
    check("simul.mbyteenable", {28'd0, bus.mbyteenable}, 32'hF);
    check("simul.iwait", {31'd0, bus.iwaitrequest}, 32'd1);
    next_cycle();
    bus.dwrite = 1'b0;
    @(negedge clk);
    check("simul2.owner", {30'd0, arb_owner}, 32'd1);
    check("simul2.maddress", bus.maddress, 32'h40);
    check("simul2.iwait", {31'd0, bus.iwaitrequest}, 32'd0);
    next_cycle();
    idle();
    next_cycle();

    // Lock hold: 3 stall cycles then completion
    bus.iread        = 1'b1;
    bus.iaddress     = 32'h80;
    bus.dread        = 1'b1;
    bus.daddress     = 32'h200;
    bus.mwaitrequest = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus.mwaitrequest = 1'b0;
      @(negedge clk);
      check("lock.owner", {30'd0, arb_owner}, 32'd2);
      check("lock.maddress", bus.maddress, 32'h200);
      check("lock.iwait", {31'd0, bus.iwaitrequest}, 32'd1);
      next_cycle();
    end
    bus.dread = 1'b0;
    @(negedge clk);
    check("lock5.owner", {30'd0, arb_owner}, 32'd1);
    check("lock5.maddress", bus.maddress, 32'h80);
    next_cycle();
    idle();
    next_cycle();

    // Starvation guard
    bus.iread    = 1'b1;
    bus.iaddress = 32'hC0;
    bus.dread    = 1'b1;
    bus.daddress = 32'h400;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seq[c] = int'(arb_owner);
      next_cycle();
    end
    for (int c = 0; c < 6; c++) check($sformatf("starve.grant%0d", c), seq[c], exp_starve[c]);
    idle();
    next_cycle();

    // Reset asserted while data is locked
    bus.iread        = 1'b1;
    bus.iaddress     = 32'hE0;
    bus.dread        = 1'b1;
    bus.daddress     = 32'h300;
    bus.mwaitrequest = 1'b1;
    @(negedge clk);
    check("rlock.owner", {30'd0, arb_owner}, 32'd2);
    next_cycle();
    reset     = 1'b1;
    bus.dread = 1'b0;
    #1;
    check("rlock.async_owner", {30'd0, arb_owner}, 32'd1);
    check("rlock.dwait", {31'd0, bus.dwaitrequest}, 32'd1);
    next_cycle();
    reset            = 1'b0;
    bus.mwaitrequest = 1'b0;
    @(negedge clk);
    check("rlock.after_owner", {30'd0, arb_owner}, 32'd1);
    next_cycle();
    idle();
    next_cycle();

    // Request drop while locked: no transfer counted
    bus.iread    = 1'b1;
    bus.iaddress = 32'hF0;
    bus.dread    = 1'b1;
    bus.daddress = 32'h500;
    next_cycle();
    bus.mwaitrequest = 1'b1;
    next_cycle();
    bus.dread = 1'b0;
    @(negedge clk);
    check("drop.owner", {30'd0, arb_owner}, 32'd2);
    check("drop.mread", {31'd0, bus.mread}, 32'd0);
    next_cycle();
    bus.dread        = 1'b1;
    bus.mwaitrequest = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("drop.grant%0d", c), {30'd0, arb_owner}, exp_drop[c]);
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Two-requester arbiter that shares one single-ported, waitrequest-style memory between the `rv32i_cpu_core` instruction port (read-only) and data port (read/write). It sits between the core and a unified program/data memory, so a single RAM or bus slave can serve both. Data accesses have priority, and a bounded starvation guard keeps instruction fetch progressing. Grants are held (locked) across multi-cycle waitrequest stalls, and the arbitration path adds no latency.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive completed data transfers, while `iread` is pending, after which the instruction side wins the next arbitration. Range 1–15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset. Design has one clock; reset is asynchronous and active-high.
- `iaddress` in 32: instruction byte address.
- `iread` in 1: instruction read request.
- `ireaddata` out 32: equals `mreaddata`.
- `iwaitrequest` out 1: instruction stall.
- `daddress` in 32: data byte address.
- `dwrite` in 1: data write request.
- `dwritedata` in 32: write data.
- `dbyteenable` in 4: write byte enables.
- `dread` in 1: data read request.
- `dreaddata` out 32: equals `mreaddata`.
- `dwaitrequest` out 1: data stall.
- `maddress` out 32: shared memory address.
- `mwrite` out 1: shared memory write strobe.
- `mwritedata` out 32: shared memory write data.
- `mbyteenable` out 4: shared memory byte enables.
- `mread` out 1: shared memory read strobe.
- `mreaddata` in 32: shared memory read data.
- `mwaitrequest` in 1: shared memory stall.
- `arb_owner` out 2: debug view of the current owner. 0 = none, 1 = instr, 2 = data.

## Operation
State machine states:
- `ARB`: free arbitration.
- `LOCK_I`: instruction side holds the grant.
- `LOCK_D`: data side holds the grant.

Starvation counter `scnt`: 4 bits, saturating at `STARVE_LIMIT`.

Grant selection in `ARB` (combinational):
- `dreq = dread | dwrite`.
- Grant data if `dreq` and not (`iread` and `scnt == STARVE_LIMIT`).
- Otherwise grant instruction if `iread`.
- Otherwise no grant.

Granted side:
- Its address, strobes, write data and byte enables drive the `m*` outputs.
- Its waitrequest equals `mwaitrequest`.

Non-granted side:
- Its waitrequest is 1.

No grant:
- `mread = mwrite = 0`.
- `maddress`, `mwritedata` and `mbyteenable` follow the data-side inputs.
- `iwaitrequest = dwaitrequest = 1`.

Read data is broadcast: `ireaddata = dreaddata = mreaddata`. Reads complete in the cycle the strobe is high and `mwaitrequest` is 0.

Lock rules:
- In `ARB`: a grant with `mwaitrequest = 1` moves to `LOCK_I` or `LOCK_D`.
- In `LOCK_x`: the owner keeps the port regardless of the other side's request.
- Leaving `LOCK_x`: the cycle the owner's strobe is high with `mwaitrequest = 0` completes the transfer, and the next state is `ARB`.
- An owner that drops its strobe while locked releases the lock: next state `ARB`, and no transfer is counted.

Starvation counter updates on a completed transfer:
- Data transfer with `iread = 1`: `scnt` increments, saturating.
- Instruction transfer: `scnt` clears.
- Any cycle with `iread = 0`: `scnt` clears.

Other rules:
- `dread` and `dwrite` high together is a requester error. Both are passed through unchanged and it counts as one data transfer.
- `arb_owner` reports the current owner: the combinational grant when in `ARB`, the locked side otherwise.
- On `reset`: state `ARB`, `scnt = 0`. All outputs are then combinational functions of the inputs per the rules above. With no requests: `mread = mwrite = 0`, both waitrequests 1, `arb_owner = 0`.
- Reset asserted mid-lock: the lock is dropped immediately (asynchronous), and arbitration restarts in `ARB` on the first edge after release.

## Timing
- Zero added latency. A request presented in `ARB` reaches the `m*` port in the same cycle.
- A zero-wait memory therefore completes one transfer per cycle with no idle cycles between grants.
- State and `scnt` register on the `clk` edge. Grant muxing is purely combinational from the state and requests.
- A waitrequest stall of N cycles holds the grant for N+1 cycles (the N stall cycles plus the completion cycle). Rearbitration happens in the cycle after completion.
- Worst-case instruction wait while data is continuously requested: `STARVE_LIMIT` data transfers, plus their waitrequest stalls, plus the in-flight lock.
- Handshake obligation: each requester holds its address, strobes and data stable while its waitrequest is 1.

## Test plan
- **Reset and idle:** after `reset` with no requests, `mread = mwrite = 0`, `iwaitrequest = dwaitrequest = 1`, `arb_owner = 0`.
- **Instruction-only pass-through:** `iread = 1` with `iaddress` stepping 0x0, 0x4, 0x8 and a zero-wait memory → `maddress` follows each cycle, `iwaitrequest = 0`, `ireaddata = mreaddata`.
- **Simultaneous requests:** `iread` and `dwrite` in the same cycle with `daddress = 0x100`, `dwritedata = 0xDEADBEEF`, `dbyteenable = 0xF` → data wins, `mwrite = 1` with those values, `iwaitrequest = 1`; instruction is granted the next cycle.
- **Lock hold:** `dread` granted with `mwaitrequest` high for 3 cycles while `iread` pending → the data grant holds all 4 cycles; `iaddress` appears on `maddress` only on cycle 5.
- **Starvation guard:** `STARVE_LIMIT = 4`, continuous `dread` and `iread` → grant order D, D, D, D, I, then D again with `scnt` cleared.
- **Reset mid-lock:** assert `reset` in `LOCK_D` during a stall → the next state is `ARB` and `arb_owner` reflects the new combinational grant. Then request-drop while locked: `dread` falls with `mwaitrequest = 1` → the lock releases and `scnt` is unchanged.
